// File: rtl/motor_column_sequencer_if.sv
// Control/handshake bundle between the pfs_bus control registers, the column
// sequencer and motor_mux's column drive.
interface motor_column_sequencer_if #(
    parameter int NCOLS = 8
) ();
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    logic             soft_reset;
    logic             run;
    logic [NCOLS-1:0] col_mask;
    logic             col_finished;
    logic [NCOLS-1:0] col_en;
    logic             col_start;
    logic [CW-1:0]    cur_col;
    logic             ready;
    logic             done;
    logic             timeout_err;
    logic [CW-1:0]    timeout_col;

    modport master (
        output soft_reset, run, col_mask, col_finished,
        input  col_en, col_start, cur_col, ready, done, timeout_err, timeout_col
    );

    modport slave (
        input  soft_reset, run, col_mask, col_finished,
        output col_en, col_start, cur_col, ready, done, timeout_err, timeout_col
    );
endinterface

// File: rtl/motor_column_sequencer.sv
// Walks the enabled motor columns of one run in ascending order with settle,
// watchdog and break-before-make dead time; every output is registered.
module motor_column_sequencer #(
    parameter int          NCOLS          = 8,
    parameter int          DEAD_CYCLES    = 16,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
    input logic                     i_clk,
    input logic                     i_rst,
    motor_column_sequencer_if.slave bus
);
    localparam int               CW        = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam logic [23:0]      PHASE_TC  = 24'(DEAD_CYCLES - 1);
    localparam logic [23:0]      WD_TC     = TIMEOUT_CYCLES - 24'd1;
    localparam logic [CW-1:0]    LAST_COL  = CW'(NCOLS - 1);
    localparam logic [NCOLS-1:0] ONE_HOT_0 = NCOLS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SETTLE, S_RUN, S_DEAD, S_FINISH
    } state_t;

    state_t           r_state, w_next;
    logic [NCOLS-1:0] r_pending, w_pending;
    logic [CW-1:0]    r_idx, w_idx;
    logic [CW-1:0]    r_cur_col, w_cur_col;
    logic [CW-1:0]    r_tcol, w_tcol;
    logic [23:0]      r_cnt, w_cnt;
    logic             r_terr, w_terr;
    logic             w_scan_hit;
    logic [CW-1:0]    w_scan_col;
    logic [NCOLS-1:0] r_col_en;
    logic             r_col_start, r_ready, r_done;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    // Lowest pending column at or above the scan index.
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_col = '0;
        for (int i = NCOLS - 1; i >= 0; i--) begin
            if (r_pending[i] && (i >= int'(r_idx))) begin
                w_scan_hit = 1'b1;
                w_scan_col = CW'(i);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pending = r_pending;
        w_idx     = r_idx;
        w_cur_col = r_cur_col;
        w_cnt     = r_cnt;
        w_terr    = r_terr;
        w_tcol    = r_tcol;
        if (bus.soft_reset) begin
            w_next    = S_IDLE;
            w_pending = '0;
            w_idx     = '0;
            w_cnt     = '0;
            w_terr    = 1'b0;
            w_tcol    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        if (|bus.col_mask) begin
                            w_pending = bus.col_mask;
                            w_idx     = '0;
                            w_terr    = 1'b0;
                            w_next    = S_SCAN;
                        end else begin
                            w_next = S_FINISH;
                        end
                    end
                end
                S_SCAN: begin
                    w_cnt = '0;
                    if (w_scan_hit) begin
                        w_cur_col = w_scan_col;
                        w_next    = S_SETTLE;
                    end else begin
                        w_next = S_FINISH;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == PHASE_TC) begin
                        w_cnt  = '0;
                        w_next = S_RUN;
                    end else begin
                        w_cnt = sat_inc(r_cnt);
                    end
                end
                S_RUN: begin
                    // Completion has priority over a watchdog expiring in the same cycle.
                    if (bus.col_finished) begin
                        w_pending[r_cur_col] = 1'b0;
                        w_cnt                = '0;
                        w_next               = S_DEAD;
                    end else if (r_cnt == WD_TC) begin
                        w_terr               = 1'b1;
                        w_tcol               = r_terr ? r_tcol : r_cur_col;
                        w_pending[r_cur_col] = 1'b0;
                        w_cnt                = '0;
                        w_next               = S_DEAD;
                    end else begin
                        w_cnt = sat_inc(r_cnt);
                    end
                end
                S_DEAD: begin
                    if (r_cnt == PHASE_TC) begin
                        w_cnt = '0;
                        if (r_cur_col == LAST_COL) begin
                            w_next = S_FINISH;
                        end else begin
                            w_idx  = r_cur_col + 1'b1;
                            w_next = S_SCAN;
                        end
                    end else begin
                        w_cnt = sat_inc(r_cnt);
                    end
                end
                S_FINISH: w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_idx       <= '0;
            r_cur_col   <= '0;
            r_cnt       <= '0;
            r_terr      <= 1'b0;
            r_tcol      <= '0;
            r_col_en    <= '0;
            r_col_start <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pending   <= w_pending;
            r_idx       <= w_idx;
            r_cur_col   <= w_cur_col;
            r_cnt       <= w_cnt;
            r_terr      <= w_terr;
            r_tcol      <= w_tcol;
            r_col_en    <= ((w_next == S_SETTLE) || (w_next == S_RUN)) ? (ONE_HOT_0 << w_cur_col) : '0;
            r_col_start <= (w_next == S_RUN) && (r_state != S_RUN);
            r_ready     <= (w_next == S_IDLE);
            r_done      <= (w_next == S_FINISH);
        end
    end

    assign bus.col_en      = r_col_en;
    assign bus.col_start   = r_col_start;
    assign bus.cur_col     = r_cur_col;
    assign bus.ready       = r_ready;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_terr;
    assign bus.timeout_col = r_tcol;
endmodule

// File: tb/tb_motor_column_sequencer.sv
// Bench for motor_column_sequencer: a sweep-timeline model predicts every output
// cycle by cycle for two instances (long and short watchdog).
module tb_motor_column_sequencer;
    localparam int NC   = 8;
    localparam int D    = 16;
    localparam int MAXC = 2048;

    typedef struct packed {
        logic [NC-1:0] en;
        logic          st;
        logic [2:0]    cur;
        logic          rdy;
        logic          dn;
        logic          err;
        logic [2:0]    tcol;
    } exp_t;

    logic clk, rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    motor_column_sequencer_if #(.NCOLS(NC)) ifa ();
    motor_column_sequencer_if #(.NCOLS(NC)) ifb ();

    motor_column_sequencer #(.NCOLS(NC), .DEAD_CYCLES(D), .TIMEOUT_CYCLES(24'd1000)) u_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa));
    motor_column_sequencer #(.NCOLS(NC), .DEAD_CYCLES(D), .TIMEOUT_CYCLES(24'd100)) u_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb));

    int            wd_len [2] = '{1000, 100};
    exp_t          ex [2][MAXC];
    logic          run_drv [2][MAXC];
    logic          fin_drv [2][MAXC];
    logic          soft_drv [2][MAXC];
    logic [NC-1:0] mask_drv [2][MAXC];
    int            tid_arr [MAXC];
    int            tinst [10];
    int            en_hi [10], starts [10], dones [10], err_dn [10], tcol_dn [10];
    logic [2:0]    m_cur [2];
    logic          m_err [2];
    logic [2:0]    m_tcol [2];
    int            g_dly [NC];
    int            col_s [NC];
    exp_t          act [2];
    exp_t          a_sel;
    int            end_c, r_at;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic put(int i, int t, logic [NC-1:0] en, logic st, logic rdy, logic dn);
        ex[i][t] = '{en: en, st: st, cur: m_cur[i], rdy: rdy, dn: dn, err: m_err[i], tcol: m_tcol[i]};
    endtask

    task automatic idle_fill(int i, int from);
        for (int t = from; t < MAXC; t++) put(i, t, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_dly(int v);
        for (int c = 0; c < NC; c++) g_dly[c] = v;
    endtask

    // One accepted run sampled at edge n; g_dly[c] is cycles from col_start to col_finished (<0: never).
    task automatic sweep(int i, int n, logic [NC-1:0] mask, int tid, output int e);
        int t, s, m;
        logic to, last;
        logic [NC-1:0] oh;
        run_drv[i][n-1]  = 1'b1;
        mask_drv[i][n-1] = mask;
        for (int k = n - 1; k < MAXC; k++) tid_arr[k] = tid;
        tinst[tid] = i;
        if (mask == '0) begin
            put(i, n, '0, 1'b0, 1'b0, 1'b1);
            idle_fill(i, n + 1);
            e = n + 1;
            return;
        end
        m_err[i] = 1'b0;
        last = 1'b0;
        t = n;
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                put(i, t, '0, 1'b0, 1'b0, 1'b0);
                m_cur[i] = 3'(c);
                oh = '0;
                oh[c] = 1'b1;
                for (int k = 1; k <= D; k++) put(i, t + k, oh, 1'b0, 1'b0, 1'b0);
                s = t + D + 1;
                col_s[c] = s;
                if (g_dly[c] >= 0 && g_dly[c] <= wd_len[i] - 1) begin
                    m = s + g_dly[c] + 1;
                    fin_drv[i][s + g_dly[c]] = 1'b1;
                    to = 1'b0;
                end else begin
                    m = s + wd_len[i];
                    to = 1'b1;
                end
                for (int k = s; k < m; k++) put(i, k, oh, (k == s), 1'b0, 1'b0);
                if (to) begin
                    if (!m_err[i]) m_tcol[i] = 3'(c);
                    m_err[i] = 1'b1;
                end
                for (int k = m; k < m + D; k++) put(i, k, '0, 1'b0, 1'b0, 1'b0);
                t = m + D;
                last = (c == NC - 1);
            end
        end
        if (!last) begin
            put(i, t, '0, 1'b0, 1'b0, 1'b0);
            t++;
        end
        put(i, t, '0, 1'b0, 1'b0, 1'b1);
        idle_fill(i, t + 1);
        e = t + 1;
    endtask

    // Abort from cycle k on: idle outputs, error state cleared, later stimulus dropped.
    task automatic cut(int i, int k, logic [2:0] cur);
        m_cur[i]  = cur;
        m_err[i]  = 1'b0;
        m_tcol[i] = '0;
        for (int t = k; t < MAXC; t++) fin_drv[i][t] = 1'b0;
        idle_fill(i, k);
    endtask

    task automatic chk(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            act[0] = '{en: ifa.col_en, st: ifa.col_start, cur: ifa.cur_col, rdy: ifa.ready,
                       dn: ifa.done, err: ifa.timeout_err, tcol: ifa.timeout_col};
            act[1] = '{en: ifb.col_en, st: ifb.col_start, cur: ifb.cur_col, rdy: ifb.ready,
                       dn: ifb.done, err: ifb.timeout_err, tcol: ifb.timeout_col};
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (act[i] !== ex[i][cyc]) begin
                    miscompares++;
                    $display("FAIL cyc%0d dut%0d got en=%b st=%b cur=%0d rdy=%b dn=%b err=%b tcol=%0d want en=%b st=%b cur=%0d rdy=%b dn=%b err=%b tcol=%0d",
                             cyc, i, act[i].en, act[i].st, act[i].cur, act[i].rdy, act[i].dn, act[i].err, act[i].tcol,
                             ex[i][cyc].en, ex[i][cyc].st, ex[i][cyc].cur, ex[i][cyc].rdy, ex[i][cyc].dn,
                             ex[i][cyc].err, ex[i][cyc].tcol);
                end
            end
            if (tid_arr[cyc] > 0) begin
                a_sel = act[tinst[tid_arr[cyc]]];
                if (|a_sel.en) en_hi[tid_arr[cyc]]++;
                if (a_sel.st) starts[tid_arr[cyc]]++;
                if (a_sel.dn) begin
                    dones[tid_arr[cyc]]++;
                    err_dn[tid_arr[cyc]]  = int'(a_sel.err);
                    tcol_dn[tid_arr[cyc]] = int'(a_sel.tcol);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cyc < MAXC) begin
                ifa.run = run_drv[0][cyc];  ifa.col_finished = fin_drv[0][cyc];
                ifa.soft_reset = soft_drv[0][cyc];  ifa.col_mask = mask_drv[0][cyc];
                ifb.run = run_drv[1][cyc];  ifb.col_finished = fin_drv[1][cyc];
                ifb.soft_reset = soft_drv[1][cyc];  ifb.col_mask = mask_drv[1][cyc];
            end
        end
    end

    initial begin
        int n, e, k;
        rst = 1'b1;
        ifa.run = 1'b0; ifa.col_finished = 1'b0; ifa.soft_reset = 1'b0; ifa.col_mask = '0;
        ifb.run = 1'b0; ifb.col_finished = 1'b0; ifb.soft_reset = 1'b0; ifb.col_mask = '0;
        for (int j = 0; j < 10; j++) begin
            tinst[j] = 0; en_hi[j] = 0; starts[j] = 0; dones[j] = 0; err_dn[j] = -1; tcol_dn[j] = -1;
        end
        for (int t = 0; t < MAXC; t++) tid_arr[t] = 0;
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = '0; m_err[i] = 1'b0; m_tcol[i] = '0;
            idle_fill(i, 0);
            for (int t = 0; t < MAXC; t++) begin
                run_drv[i][t] = 1'b0; fin_drv[i][t] = 1'b0; soft_drv[i][t] = 1'b0; mask_drv[i][t] = '0;
            end
        end

        set_dly(300);                      sweep(0, 10, 8'b0000_0001, 1, e);
        n = e + 5; set_dly(5);             sweep(0, n, 8'b0001_0100, 2, e);
        fin_drv[0][n + 1] = 1'b1;
        run_drv[0][n + 3] = 1'b1;
        mask_drv[0][n] = 8'hFF;
        mask_drv[0][n + 3] = 8'hFF;
        n = e + 5; set_dly(10); g_dly[0] = -1; sweep(1, n, 8'b0000_0011, 3, e);
        n = e + 5;                         sweep(0, n, 8'b0000_0000, 4, e);
        n = e + 5; set_dly(99);            sweep(1, n, 8'b0000_0001, 5, e);
        n = e + 5; set_dly(20);            sweep(0, n, 8'b0000_0111, 6, e);
        k = col_s[1] + 5;
        soft_drv[0][k - 1] = 1'b1;
        cut(0, k, ex[0][k - 1].cur);
        n = k + 5; set_dly(8);             sweep(0, n, 8'b0000_0011, 7, e);
        n = e + 5;                         sweep(0, n, 8'b0000_0011, 8, e);
        r_at = col_s[0] + 8 + 1 + 5;
        cut(0, r_at, 3'd0);
        n = r_at + 8; set_dly(3);          sweep(0, n, 8'b0000_0001, 9, e);
        end_c = e + 5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait (cyc == r_at);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", int'(ifa.ready), 1);
        chk("async_col_en", int'(ifa.col_en), 0);
        chk("async_cur_col", int'(ifa.cur_col), 0);
        chk("async_done", int'(ifa.done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait (cyc >= end_c);
        @(negedge clk);
        chk("single_en_cycles", en_hi[1], 317);
        chk("single_starts", starts[1], 1);
        chk("single_done", dones[1], 1);
        chk("single_err", err_dn[1], 0);
        chk("sparse_starts", starts[2], 2);
        chk("sparse_done", dones[2], 1);
        chk("sparse_en_cycles", en_hi[2], 44);
        chk("timeout_en_cycles", en_hi[3], 143);
        chk("timeout_err", err_dn[3], 1);
        chk("timeout_col", tcol_dn[3], 0);
        chk("timeout_done", dones[3], 1);
        chk("empty_done", dones[4], 1);
        chk("empty_en_cycles", en_hi[4], 0);
        chk("coincide_err", err_dn[5], 0);
        chk("coincide_en_cycles", en_hi[5], 116);
        chk("soft_done", dones[6], 0);
        chk("restart_starts", starts[7], 2);
        chk("after_reset_done", dones[9], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
